hdmi_aux_receiver: RTL and testbench

Receive side of the HDMI data-island aux packet path. Deserializes the per-slot header bit and four 2-bit subpacket lanes over the 32 aux slots, then checks BCH ECC for the header and every subpacket. Reports packet type and header bytes. Decodes 2-channel audio sample packets (type 0x02) into 16-bit left/right samples with channel-status and parity checks. Sits after TERC4 decode and channel alignment in the HDMI sink/loopback path.

---
 rtl/hdmi_aux_receiver_if.sv | 36 +++
 rtl/hdmi_aux_receiver.sv | 170 +++++++++++++++++
 tb/tb_hdmi_aux_receiver.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_aux_receiver_if.sv
// Aux payload bus into the HDMI aux receiver plus its decoded packet/sample outputs.
// The master side drives slot bits; the slave side is the receiver.
interface hdmi_aux_receiver_if;
  logic        ae;
  logic [4:0]  aux_slot;
  logic        header;
  logic [1:0]  sub0;
  logic [1:0]  sub1;
  logic [1:0]  sub2;
  logic [1:0]  sub3;

  logic        pkt_valid;
  logic [7:0]  pkt_hb0;
  logic [7:0]  pkt_hb1;
  logic [7:0]  pkt_hb2;
  logic        hdr_ecc_ok;
  logic [3:0]  sub_ecc_ok;
  logic        sample_strobe;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic [1:0]  sample_cs;
  logic        block_start;
  logic [1:0]  parity_err;

  modport master (
    output ae, aux_slot, header, sub0, sub1, sub2, sub3,
    input  pkt_valid, pkt_hb0, pkt_hb1, pkt_hb2, hdr_ecc_ok, sub_ecc_ok,
    input  sample_strobe, sample_left, sample_right, sample_cs, block_start, parity_err
  );

  modport slave (
    input  ae, aux_slot, header, sub0, sub1, sub2, sub3,
    output pkt_valid, pkt_hb0, pkt_hb1, pkt_hb2, hdr_ecc_ok, sub_ecc_ok,
    output sample_strobe, sample_left, sample_right, sample_cs, block_start, parity_err
  );
endinterface

// File: rtl/hdmi_aux_receiver.sv
// HDMI data-island aux packet receiver: slot deserializer, serial BCH check per block,
// and 2-channel audio sample decode for packet type 0x02.
module hdmi_aux_receiver (
  input  logic              clk,
  input  logic              reset,
  hdmi_aux_receiver_if.slave aux
);

  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic d);
    logic fb;
    fb = ecc[0] ^ d;
    return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
  endfunction

  logic [4:0]  exp_slot_q, exp_slot_d;
  logic [31:0] hdr_sr_q, hdr_sr_d;
  logic [63:0] sub_sr_q [4];
  logic [63:0] sub_sr_d [4];
  logic [7:0]  hdr_ecc_q, hdr_ecc_d;
  logic [7:0]  sub_ecc_q [4];
  logic [7:0]  sub_ecc_d [4];

  logic        pkt_valid_q, pkt_valid_d;
  logic [7:0]  pkt_hb0_q, pkt_hb0_d;
  logic [7:0]  pkt_hb1_q, pkt_hb1_d;
  logic [7:0]  pkt_hb2_q, pkt_hb2_d;
  logic        hdr_ecc_ok_q, hdr_ecc_ok_d;
  logic [3:0]  sub_ecc_ok_q, sub_ecc_ok_d;
  logic        sample_strobe_q, sample_strobe_d;
  logic [15:0] sample_left_q, sample_left_d;
  logic [15:0] sample_right_q, sample_right_d;
  logic [1:0]  sample_cs_q, sample_cs_d;
  logic        block_start_q, block_start_d;
  logic [1:0]  parity_err_q, parity_err_d;

  logic [1:0]  sub_in [4];
  logic        start, take, done;
  logic        hdr_ok;
  logic [3:0]  sub_ok;
  logic [15:0] left_w, right_w;
  logic [7:0]  vucp_w;

  assign sub_in[0] = aux.sub0;
  assign sub_in[1] = aux.sub1;
  assign sub_in[2] = aux.sub2;
  assign sub_in[3] = aux.sub3;

  // Slot 0 always (re)starts a packet; any other out-of-order slot or an ae drop clears state.
  always_comb begin
    start      = aux.ae && (aux.aux_slot == 5'd0);
    take       = aux.ae && ((aux.aux_slot == exp_slot_q) || start);
    done       = take && (aux.aux_slot == 5'd31);
    exp_slot_d = take ? (aux.aux_slot + 5'd1) : 5'd0;

    hdr_sr_d  = hdr_sr_q;
    sub_sr_d  = sub_sr_q;
    hdr_ecc_d = 8'h00;
    for (int n = 0; n < 4; n++) sub_ecc_d[n] = 8'h00;

    if (take) begin
      hdr_sr_d[aux.aux_slot] = aux.header;
      hdr_ecc_d = start ? 8'h00 : hdr_ecc_q;
      if (aux.aux_slot < 5'd24) hdr_ecc_d = ecc_step(hdr_ecc_d, aux.header);
      for (int n = 0; n < 4; n++) begin
        sub_sr_d[n][{aux.aux_slot, 1'b0} +: 2] = sub_in[n];
        sub_ecc_d[n] = start ? 8'h00 : sub_ecc_q[n];
        if (aux.aux_slot < 5'd28) begin
          sub_ecc_d[n] = ecc_step(sub_ecc_d[n], sub_in[n][0]);
          sub_ecc_d[n] = ecc_step(sub_ecc_d[n], sub_in[n][1]);
        end
      end
    end

    // Parity slots never advance the LFSRs, so the held value is final when slot 31 lands.
    hdr_ok = (hdr_ecc_q == hdr_sr_d[31:24]);
    for (int n = 0; n < 4; n++) sub_ok[n] = (sub_ecc_q[n] == sub_sr_d[n][63:56]);

    left_w  = sub_sr_d[0][23:8];
    right_w = sub_sr_d[0][47:32];
    vucp_w  = sub_sr_d[0][55:48];

    pkt_valid_d     = 1'b0;
    sample_strobe_d = 1'b0;
    pkt_hb0_d       = pkt_hb0_q;
    pkt_hb1_d       = pkt_hb1_q;
    pkt_hb2_d       = pkt_hb2_q;
    hdr_ecc_ok_d    = hdr_ecc_ok_q;
    sub_ecc_ok_d    = sub_ecc_ok_q;
    sample_left_d   = sample_left_q;
    sample_right_d  = sample_right_q;
    sample_cs_d     = sample_cs_q;
    block_start_d   = block_start_q;
    parity_err_d    = parity_err_q;

    if (done) begin
      pkt_valid_d  = 1'b1;
      pkt_hb0_d    = hdr_sr_d[7:0];
      pkt_hb1_d    = hdr_sr_d[15:8];
      pkt_hb2_d    = hdr_sr_d[23:16];
      hdr_ecc_ok_d = hdr_ok;
      sub_ecc_ok_d = sub_ok;
      if ((hdr_sr_d[7:0] == 8'h02) && hdr_sr_d[8] && hdr_ok && sub_ok[0]) begin
        sample_strobe_d = 1'b1;
        sample_left_d   = left_w;
        sample_right_d  = right_w;
        sample_cs_d     = {vucp_w[6], vucp_w[2]};
        block_start_d   = hdr_sr_d[20];
        parity_err_d    = {^{right_w, vucp_w[7:4]}, ^{left_w, vucp_w[3:0]}};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_slot_q      <= 5'd0;
      hdr_sr_q        <= 32'd0;
      hdr_ecc_q       <= 8'h00;
      for (int n = 0; n < 4; n++) begin
        sub_sr_q[n]  <= 64'd0;
        sub_ecc_q[n] <= 8'h00;
      end
      pkt_valid_q     <= 1'b0;
      pkt_hb0_q       <= 8'h00;
      pkt_hb1_q       <= 8'h00;
      pkt_hb2_q       <= 8'h00;
      hdr_ecc_ok_q    <= 1'b0;
      sub_ecc_ok_q    <= 4'h0;
      sample_strobe_q <= 1'b0;
      sample_left_q   <= 16'h0000;
      sample_right_q  <= 16'h0000;
      sample_cs_q     <= 2'b00;
      block_start_q   <= 1'b0;
      parity_err_q    <= 2'b00;
    end else begin
      exp_slot_q      <= exp_slot_d;
      hdr_sr_q        <= hdr_sr_d;
      hdr_ecc_q       <= hdr_ecc_d;
      for (int n = 0; n < 4; n++) begin
        sub_sr_q[n]  <= sub_sr_d[n];
        sub_ecc_q[n] <= sub_ecc_d[n];
      end
      pkt_valid_q     <= pkt_valid_d;
      pkt_hb0_q       <= pkt_hb0_d;
      pkt_hb1_q       <= pkt_hb1_d;
      pkt_hb2_q       <= pkt_hb2_d;
      hdr_ecc_ok_q    <= hdr_ecc_ok_d;
      sub_ecc_ok_q    <= sub_ecc_ok_d;
      sample_strobe_q <= sample_strobe_d;
      sample_left_q   <= sample_left_d;
      sample_right_q  <= sample_right_d;
      sample_cs_q     <= sample_cs_d;
      block_start_q   <= block_start_d;
      parity_err_q    <= parity_err_d;
    end
  end

  assign aux.pkt_valid     = pkt_valid_q;
  assign aux.pkt_hb0       = pkt_hb0_q;
  assign aux.pkt_hb1       = pkt_hb1_q;
  assign aux.pkt_hb2       = pkt_hb2_q;
  assign aux.hdr_ecc_ok    = hdr_ecc_ok_q;
  assign aux.sub_ecc_ok    = sub_ecc_ok_q;
  assign aux.sample_strobe = sample_strobe_q;
  assign aux.sample_left   = sample_left_q;
  assign aux.sample_right  = sample_right_q;
  assign aux.sample_cs     = sample_cs_q;
  assign aux.block_start   = block_start_q;
  assign aux.parity_err    = parity_err_q;

endmodule

// File: tb/tb_hdmi_aux_receiver.sv
// Bench for hdmi_aux_receiver: directed vector table, slot-sequencing corner cases,
// then randomized packets scored against a whole-packet reference model.
module tb_hdmi_aux_receiver;

  typedef struct packed {
    logic [23:0]       hb;
    logic [3:0][55:0]  sb;
  } pkt_t;

  typedef struct packed {
    logic [23:0] hb;
    logic        hdr_ok;
    logic [3:0]  sub_ok;
    logic        strobe;
    logic [15:0] l;
    logic [15:0] r;
    logic [1:0]  cs;
    logic        bs;
    logic [1:0]  perr;
  } exp_t;

  typedef struct {
    pkt_t p;
    int   flipBlk;
    int   flipBit;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdmi_aux_receiver_if bus ();
  hdmi_aux_receiver dut (.clk(clk), .reset(reset), .aux(bus));

  int checks = 0;
  int errors = 0;
  int validCount = 0;
  bit sbEn = 1'b0;
  exp_t sbQ [$];

  logic [15:0] mL = 0, mR = 0;
  logic [1:0]  mCs = 0, mPerr = 0;
  logic        mBs = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // BCH parity as a plain bit-serial remainder over the data bits, LSB first.
  function automatic logic [7:0] bchModel(input logic [63:0] data, input int nbits);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      fb = r[0] ^ data[i];
      r  = (r >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return r;
  endfunction

  function automatic pkt_t makeAudio(input logic [15:0] l, input logic [15:0] r,
                                     input logic [7:0] vucp, input logic [7:0] hb2);
    pkt_t p;
    p.hb    = {hb2, 8'h01, 8'h02};
    p.sb    = '0;
    p.sb[0] = {vucp, r, 8'h00, l, 8'h00};
    return p;
  endfunction

  function automatic exp_t mkExp(input logic [23:0] hb, input logic hdrOk, input logic strobe,
                                 input logic [15:0] l, input logic [15:0] r, input logic [1:0] cs,
                                 input logic bs, input logic [1:0] perr);
    exp_t e;
    e.hb = hb; e.hdr_ok = hdrOk; e.sub_ok = 4'hF; e.strobe = strobe;
    e.l = l; e.r = r; e.cs = cs; e.bs = bs; e.perr = perr;
    return e;
  endfunction

  // flipBlk: 0 none, 1 header word, 2..5 subpacket 0..3 word
  task automatic buildWords(input pkt_t p, input int flipBlk, input int flipBit,
                            output logic [31:0] hw, output logic [3:0][63:0] sw);
    hw = {bchModel({40'd0, p.hb}, 24), p.hb};
    for (int n = 0; n < 4; n++) sw[n] = {bchModel({8'd0, p.sb[n]}, 56), p.sb[n]};
    if (flipBlk == 1) hw[flipBit] = ~hw[flipBit];
    else if (flipBlk >= 2) sw[flipBlk-2][flipBit] = ~sw[flipBlk-2][flipBit];
  endtask

  task automatic modelPacket(input pkt_t p, input int flipBlk, input int flipBit, output exp_t e);
    logic [31:0] hw;
    logic [3:0][63:0] sw;
    logic [7:0] vucp;
    buildWords(p, flipBlk, flipBit, hw, sw);
    e.hb     = hw[23:0];
    e.hdr_ok = (hw[31:24] == bchModel({40'd0, hw[23:0]}, 24));
    for (int n = 0; n < 4; n++) e.sub_ok[n] = (sw[n][63:56] == bchModel({8'd0, sw[n][55:0]}, 56));
    e.strobe = (e.hb[7:0] == 8'h02) && e.hb[8] && e.hdr_ok && e.sub_ok[0];
    if (e.strobe) begin
      mL    = sw[0][23:8];
      mR    = sw[0][47:32];
      vucp  = sw[0][55:48];
      mCs   = {vucp[6], vucp[2]};
      mBs   = e.hb[20];
      mPerr = {^{mR, vucp[7:4]}, ^{mL, vucp[3:0]}};
    end
    e.l = mL; e.r = mR; e.cs = mCs; e.bs = mBs; e.perr = mPerr;
  endtask

  task automatic applyStimulus(input pkt_t p, input int flipBlk, input int flipBit,
                               input int firstSlot, input int lastSlot);
    logic [31:0] hw;
    logic [3:0][63:0] sw;
    buildWords(p, flipBlk, flipBit, hw, sw);
    for (int s = firstSlot; s <= lastSlot; s++) begin
      @(negedge clk);
      bus.ae       = 1'b1;
      bus.aux_slot = 5'(s);
      bus.header   = hw[s];
      bus.sub0     = sw[0][2*s +: 2];
      bus.sub1     = sw[1][2*s +: 2];
      bus.sub2     = sw[2][2*s +: 2];
      bus.sub3     = sw[3][2*s +: 2];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ae = 1'b0;
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".pkt_valid"}, bus.pkt_valid, 1);
    checkOutput({tag, ".hb"}, {bus.pkt_hb2, bus.pkt_hb1, bus.pkt_hb0}, e.hb);
    checkOutput({tag, ".hdr_ecc_ok"}, bus.hdr_ecc_ok, e.hdr_ok);
    checkOutput({tag, ".sub_ecc_ok"}, bus.sub_ecc_ok, e.sub_ok);
    checkOutput({tag, ".strobe"}, bus.sample_strobe, e.strobe);
    checkOutput({tag, ".left"}, bus.sample_left, e.l);
    checkOutput({tag, ".right"}, bus.sample_right, e.r);
    checkOutput({tag, ".cs"}, bus.sample_cs, e.cs);
    checkOutput({tag, ".block_start"}, bus.block_start, e.bs);
    checkOutput({tag, ".parity_err"}, bus.parity_err, e.perr);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".flags"}, {bus.pkt_valid, bus.sample_strobe, bus.hdr_ecc_ok, bus.sub_ecc_ok,
                                  bus.sample_cs, bus.block_start, bus.parity_err}, 0);
    checkOutput({tag, ".hb"}, {bus.pkt_hb2, bus.pkt_hb1, bus.pkt_hb0}, 0);
    checkOutput({tag, ".samples"}, {bus.sample_left, bus.sample_right}, 0);
  endtask

  always @(negedge clk) begin
    if (bus.pkt_valid) validCount++;
    if (sbEn && bus.pkt_valid) begin
      if (sbQ.size() == 0) checkOutput("sb_unexpected_pkt", 1, 0);
      else checkAll("rand", sbQ.pop_front());
    end
  end

  vec_t tbl [5];

  initial begin
    exp_t e;
    pkt_t pA, pB;
    int v0, fb, fbit, gap;
    logic [63:0] rnd;

    reset = 1'b1;
    bus.ae = 1'b0; bus.aux_slot = '0; bus.header = 1'b0;
    bus.sub0 = '0; bus.sub1 = '0; bus.sub2 = '0; bus.sub3 = '0;

    tbl[0] = '{makeAudio(16'h1234, 16'hABCD, 8'hC4, 8'h00), 0, 0,
               mkExp(24'h000102, 1, 1, 16'h1234, 16'hABCD, 2'b11, 0, 2'b00)};
    tbl[1] = '{makeAudio(16'h1234, 16'hABCD, 8'hC4, 8'h10), 0, 0,
               mkExp(24'h100102, 1, 1, 16'h1234, 16'hABCD, 2'b11, 1, 2'b00)};
    tbl[2] = '{makeAudio(16'h1234, 16'hABCD, 8'hCC, 8'h10), 0, 0,
               mkExp(24'h100102, 1, 1, 16'h1234, 16'hABCD, 2'b11, 1, 2'b01)};
    tbl[3] = '{makeAudio(16'h1234, 16'hABCD, 8'hC4, 8'h00), 1, 5,
               mkExp(24'h000122, 0, 0, 16'h1234, 16'hABCD, 2'b11, 1, 2'b01)};
    tbl[4].p.hb = 24'h000001;
    for (int n = 0; n < 4; n++) tbl[4].p.sb[n] = 56'h00_FA_00_00_10_00_00;
    tbl[4].flipBlk = 0; tbl[4].flipBit = 0;
    tbl[4].e = mkExp(24'h000001, 1, 0, 16'h1234, 16'hABCD, 2'b11, 1, 2'b01);

    @(negedge clk);
    checkZero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      modelPacket(tbl[i].p, tbl[i].flipBlk, tbl[i].flipBit, e);
      applyStimulus(tbl[i].p, tbl[i].flipBlk, tbl[i].flipBit, 0, 31);
      idle(1);
      checkAll($sformatf("vec%0d", i), tbl[i].e);
      idle(1);
      checkOutput($sformatf("vec%0d.pulse_end", i), {bus.pkt_valid, bus.sample_strobe}, 0);
    end

    pA = makeAudio(16'h5A0F, 16'h0F5A, 8'h44, 8'h10);
    pB = makeAudio(16'hFFFF, 16'h0001, 8'h00, 8'h00);

    // Mismatched slot 20 drops the partial packet; only the fresh one is reported.
    v0 = validCount;
    applyStimulus(pB, 0, 0, 0, 9);
    applyStimulus(pB, 0, 0, 20, 20);
    modelPacket(pA, 0, 0, e);
    applyStimulus(pA, 0, 0, 0, 31);
    idle(1);
    checkAll("seq_skip", e);
    idle(2);
    checkOutput("seq_skip.count", validCount - v0, 1);

    v0 = validCount;
    applyStimulus(pB, 0, 0, 0, 12);
    modelPacket(pA, 0, 0, e);
    applyStimulus(pA, 0, 0, 0, 31);
    idle(3);
    checkOutput("seq_restart.count", validCount - v0, 1);

    v0 = validCount;
    applyStimulus(pB, 0, 0, 0, 14);
    idle(1);
    applyStimulus(pB, 0, 0, 15, 31);
    idle(3);
    checkOutput("seq_aedrop.count", validCount - v0, 0);

    v0 = validCount;
    applyStimulus(pB, 0, 0, 0, 15);
    @(negedge clk);
    reset = 1'b1;
    bus.ae = 1'b0;
    #1;
    checkZero("midreset");
    mL = 0; mR = 0; mCs = 0; mBs = 0; mPerr = 0;
    @(negedge clk);
    reset = 1'b0;
    pA = makeAudio(16'h8001, 16'h7FFE, 8'h40, 8'h00);
    modelPacket(pA, 0, 0, e);
    applyStimulus(pA, 0, 0, 0, 31);
    idle(1);
    checkAll("seq_reset", e);
    idle(2);
    checkOutput("seq_reset.count", validCount - v0, 1);

    // Random packets, back-to-back when gap is zero.
    sbEn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      pA.hb[7:0]   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h02;
      pA.hb[23:8]  = 16'($urandom);
      for (int n = 0; n < 4; n++) begin
        rnd = {$urandom, $urandom};
        pA.sb[n] = rnd[55:0];
      end
      fb = 0; fbit = 0;
      if ($urandom_range(0, 3) == 0) begin
        fb   = int'($urandom_range(1, 5));
        fbit = (fb == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 63));
      end
      modelPacket(pA, fb, fbit, e);
      sbQ.push_back(e);
      applyStimulus(pA, fb, fbit, 0, 31);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(3);
    sbEn = 1'b0;
    checkOutput("sb_drain", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
